hdmi_video_timing: RTL and testbench

Video timing controller that sequences the HDMI output datapath. It generates the hsync/vsync/blank raster for the TMDS encoder, requests framebuffer lines one line ahead over a req/ack handshake, and pops pixels from a first-word-fall-through line buffer. It sits in the `clk_vga` domain (108 MHz, 1280x1024@60) between the framebuffer line fetcher and the red/green/blue/hsync/vsync/blank inputs of the DVI output block.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/raster_counter.sv | 57 +++++
 rtl/hdmi_video_timing.sv | 191 +++++++++++++++++++
 tb/tb_hdmi_video_timing.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and default 1280x1024@60 timing constants for the HDMI video timing path.
package video_timing_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned PIX_W = 24;

  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 48;
  localparam int unsigned DEF_H_SYNC   = 112;
  localparam int unsigned DEF_H_BP     = 248;
  localparam int unsigned DEF_V_ACTIVE = 1024;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BP     = 38;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } vt_state_e;

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counters with wrap and end-of-frame flag.
module raster_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             eof
);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_q == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_q == CNT_W'(V_TOTAL - 1));

  // Next position: hold when idle, advance h, carry into v at end of line.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (clr) begin
      h_d = '0;
      v_d = '0;
    end else if (en) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h   = h_q;
  assign v   = v_q;
  assign eof = h_last && v_last;

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing generator: sync/blank, one-line-ahead fetch requests, FWFT pixel pops.
module hdmi_video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic             clk_vga,
  input  logic             reset,
  input  logic             enable,
  output logic             line_req,
  output logic [CNT_W-1:0] line_num,
  input  logic             line_ack,
  output logic             pix_rd,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             frame_start,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  vt_state_e        state_q, state_d;
  logic [CNT_W-1:0] h, v;
  logic             eof;
  logic             counting;

  logic             line_req_q, line_req_d;
  logic [CNT_W-1:0] line_num_q, line_num_d;
  logic             pf_due;
  logic [CNT_W-1:0] pf_line;

  logic             pix_rd_q, pix_rd_d;
  logic             blank1_q, blank1_d;
  logic             hs1_q, hs1_d;
  logic             vs1_q, vs1_d;
  logic             fs1_q, fs1_d;
  logic             act0;

  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_q, blank_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;

  assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  raster_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_raster (
    .clk  (clk_vga),
    .reset(reset),
    .clr  (!counting),
    .en   (counting),
    .h    (h),
    .v    (v),
    .eof  (eof)
  );

  // Run-state sequencing and the line fetch request handshake.
  always_comb begin
    state_d    = state_q;
    line_req_d = line_req_q;
    line_num_d = line_num_q;
    pf_due     = 1'b0;
    pf_line    = '0;

    if (line_req_q && line_ack) line_req_d = 1'b0;

    // Prefetch next line at end of active; next-frame line 0 only while running.
    if (counting && (h == CNT_W'(H_ACTIVE))) begin
      if (v < CNT_W'(V_ACTIVE - 1)) begin
        pf_due  = 1'b1;
        pf_line = v + CNT_W'(1);
      end else if ((v == CNT_W'(V_TOTAL - 1)) && (state_q == ST_RUN)) begin
        pf_due  = 1'b1;
        pf_line = '0;
      end
    end

    // A request due while one is still outstanding is dropped.
    if (pf_due && !line_req_q) begin
      line_req_d = 1'b1;
      line_num_d = pf_line;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_PRIME;
          line_req_d = 1'b1;
          line_num_d = '0;
        end
      end
      ST_PRIME: if (line_req_q && line_ack) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (eof)         state_d = ST_IDLE;
        else if (enable) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage 1 decode from the counter, stage 2 pixel capture and sticky underrun.
  always_comb begin
    act0     = counting && (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    pix_rd_d = act0;
    blank1_d = !act0;
    hs1_d    = (counting && (h >= CNT_W'(HS_START)) && (h < CNT_W'(HS_END))) ? HS_POL : ~HS_POL;
    vs1_d    = (counting && (v >= CNT_W'(VS_START)) && (v < CNT_W'(VS_END))) ? VS_POL : ~VS_POL;
    fs1_d    = counting && (h == '0) && (v == '0);

    rgb_d         = (pix_rd_q && pix_valid) ? pix_data : '0;
    hsync_d       = hs1_q;
    vsync_d       = vs1_q;
    blank_d       = blank1_q;
    frame_start_d = fs1_q;
    underrun_d    = (pix_rd_q && !pix_valid) || (underrun_q && !underrun_clr);
  end

  // All state and pipeline registers with synchronous reset.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      line_req_q    <= 1'b0;
      line_num_q    <= '0;
      pix_rd_q      <= 1'b0;
      blank1_q      <= 1'b1;
      hs1_q         <= ~HS_POL;
      vs1_q         <= ~VS_POL;
      fs1_q         <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_req_q    <= line_req_d;
      line_num_q    <= line_num_d;
      pix_rd_q      <= pix_rd_d;
      blank1_q      <= blank1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      fs1_q         <= fs1_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign line_req    = line_req_q;
  assign line_num    = line_num_q;
  assign pix_rd      = pix_rd_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing on a shrunken 24x10 raster.
module tb_hdmi_video_timing;
  import video_timing_pkg::*;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;   // 24
  localparam int VT  = VA + VFP + VSY + VBP;   // 10
  localparam int FT  = HT * VT;                // 240
  localparam int RUN_LEN = 3 * FT;             // raster runs for three frames
  localparam logic [23:0] PIX = 24'hC0FFEE;

  logic        clk_vga = 1'b0;
  logic        reset;
  logic        enable;
  logic        line_req;
  logic [10:0] line_num;
  logic        line_ack;
  logic        pix_rd;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, blank;
  logic        frame_start;
  logic        underrun;
  logic        underrun_clr;
  logic [23:0] rgb;

  assign rgb = {red, green, blue};

  always #5 clk_vga = ~clk_vga;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_vga     (clk_vga),
    .reset       (reset),
    .enable      (enable),
    .line_req    (line_req),
    .line_num    (line_num),
    .line_ack    (line_ack),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_start (frame_start),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raster position p counts cycles since RUN entry; valid only inside the run window.
  function automatic bit in_run(input int p);
    return (p >= 0) && (p < RUN_LEN);
  endfunction
  function automatic int hp(input int p);
    return p % HT;
  endfunction
  function automatic int vp(input int p);
    return (p / HT) % VT;
  endfunction
  function automatic bit act(input int p);
    return in_run(p) && (hp(p) < HA) && (vp(p) < VA);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".hsync"},    32'(hsync),       32'(0));
    chk({tag, ".vsync"},    32'(vsync),       32'(0));
    chk({tag, ".blank"},    32'(blank),       32'(1));
    chk({tag, ".rgb"},      32'(rgb),         32'(0));
    chk({tag, ".pix_rd"},   32'(pix_rd),      32'(0));
    chk({tag, ".line_req"}, 32'(line_req),    32'(0));
    chk({tag, ".line_num"}, 32'(line_num),    32'(0));
    chk({tag, ".fstart"},   32'(frame_start), 32'(0));
    chk({tag, ".underrun"}, 32'(underrun),    32'(0));
  endtask

  // Sampled at negedge k: counter is at p=k, stage 1 shows p=k-1, outputs show p=k-2.
  task automatic check_cycle(input int k);
    int q;
    int p;
    bit exp_req;
    bit exp_under;
    q = k - 1;
    p = k - 2;
    chk($sformatf("pix_rd@%0d", k), 32'(pix_rd), 32'(act(q)));
    exp_req = in_run(q) && (hp(q) == HA) &&
              ((vp(q) < VA - 1) || ((vp(q) == VT - 1) && (q / FT != 2)));
    chk($sformatf("line_req@%0d", k), 32'(line_req), 32'(exp_req));
    if (exp_req)
      chk($sformatf("line_num@%0d", k), 32'(line_num),
          32'((vp(q) == VT - 1) ? 0 : vp(q) + 1));
    chk($sformatf("blank@%0d", k), 32'(blank), 32'(!act(p)));
    chk($sformatf("hsync@%0d", k), 32'(hsync),
        32'(in_run(p) && (hp(p) >= HA + HFP) && (hp(p) < HA + HFP + HSY)));
    chk($sformatf("vsync@%0d", k), 32'(vsync),
        32'(in_run(p) && (vp(p) >= VA + VFP) && (vp(p) < VA + VFP + VSY)));
    chk($sformatf("fstart@%0d", k), 32'(frame_start), 32'(in_run(p) && (p % FT == 0)));
    chk($sformatf("rgb@%0d", k), 32'(rgb),
        32'((act(p) && (p != 322) && (p != 482)) ? PIX : 24'h0));
    exp_under = ((k >= 324) && (k <= 400)) || ((k >= 484) && (k <= 500));
    chk($sformatf("underrun@%0d", k), 32'(underrun), 32'(exp_under));
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    line_ack     = 1'b0;
    pix_data     = PIX;
    pix_valid    = 1'b1;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk_vga);
    chk_reset_vals("por");

    // Start: PRIME requests line 0, acked immediately.
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk_vga);
    chk("prime_req",   32'(line_req), 32'(1));
    chk("prime_num",   32'(line_num), 32'(0));
    chk("prime_blank", 32'(blank),    32'(1));
    line_ack = 1'b1;
    @(negedge clk_vga);
    line_ack = 1'b0;
    chk("ack_drop",  32'(line_req), 32'(0));
    chk("run0_prd",  32'(pix_rd),   32'(0));
    chk("run0_blnk", 32'(blank),    32'(1));

    // Three frames: underruns, clears, an enable dip, then a drain to IDLE.
    for (int k = 1; k <= 760; k++) begin
      @(negedge clk_vga);
      check_cycle(k);
      line_ack     = line_req;
      pix_valid    = !((k == 323) || (k == 483));
      underrun_clr = (k == 400) || (k == 483) || (k == 500);
      if ((k == 336) || (k == 528)) enable = 1'b0;
      else if (k == 360)            enable = 1'b1;
    end

    // Restart, leave a fetch outstanding and set underrun, then reset mid-line.
    enable = 1'b1;
    @(negedge clk_vga);
    chk("re_prime_req", 32'(line_req), 32'(1));
    line_ack = 1'b1;
    @(negedge clk_vga);
    line_ack = 1'b0;
    @(negedge clk_vga);
    pix_valid = 1'b0;
    @(negedge clk_vga);
    pix_valid = 1'b1;
    chk("re_fstart", 32'(frame_start), 32'(1));
    chk("re_rgb0",   32'(rgb),         32'(0));
    chk("re_under",  32'(underrun),    32'(1));
    repeat (18) @(negedge clk_vga);
    chk("pend_req",   32'(line_req), 32'(1));
    chk("pend_num",   32'(line_num), 32'(1));
    chk("pend_hsync", 32'(hsync),    32'(1));
    reset = 1'b1;
    @(negedge clk_vga);
    chk_reset_vals("mid");
    chk("mid.state", 32'(dut.state_q), 32'(ST_IDLE));
    reset  = 1'b0;
    enable = 1'b0;
    repeat (4) @(negedge clk_vga);
    chk("idle_req",   32'(line_req),      32'(0));
    chk("idle_blank", 32'(blank),         32'(1));
    chk("idle_state", 32'(dut.state_q),   32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
